// File: rtl/spi_frame_receiver.sv
// rtl/spi_frame_receiver.sv - SPI pin synchroniser, 16-bit frame shifter and frame validator
//
// Purpose: front end of the SPI register path. Brings SCLK/COPI/nCS into the clk
// domain, shifts in an MSB-first frame while nCS is low, and on nCS deassertion
// either presents the decoded write/read frame (frame_valid pulse) or discards it
// (frame_err pulse).
//
// Ports:
//   clk          system clock, the only clock in the block
//   rst          synchronous reset, active-high
//   SCLK         SPI clock pin (async, mode 0, sampled on rising edge)
//   COPI         SPI data pin (async)
//   nCS          SPI chip select pin (async, active-low)
//   frame_valid  one-cycle pulse: well-formed frame received
//   frame_write  frame MSB: 1=write, 0=read (held until next frame_valid)
//   frame_addr   address field (held until next frame_valid)
//   frame_data   data field (held until next frame_valid)
//   frame_err    one-cycle pulse: frame discarded because of a wrong bit count
//   busy         high while a frame is being received
module spi_frame_receiver #(
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_BITS   = 7,
  parameter int DATA_BITS   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 SCLK,
  input  logic                 COPI,
  input  logic                 nCS,
  output logic                 frame_valid,
  output logic                 frame_write,
  output logic [ADDR_BITS-1:0] frame_addr,
  output logic [DATA_BITS-1:0] frame_data,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int FRAME_BITS = 1 + ADDR_BITS + DATA_BITS;
  localparam int CNT_W      = $clog2(FRAME_BITS + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_BITS + 1);

  typedef enum logic [1:0] {IDLE, RECV, CHECK} state_t;

  logic [SYNC_STAGES-1:0] sclk_sync_q, copi_sync_q, ncs_sync_q;
  logic                   sclk_hist_q, ncs_hist_q;
  logic [SYNC_STAGES:0]   settle_q;
  logic                   armed_q;

  logic sclk_s, copi_s, ncs_s;
  logic sclk_rise, ncs_fall, ncs_rise;

  // Pin synchronisers. The chains reset to idle levels, so a pin held low across
  // reset looks like a falling edge once the chain refills. settle_q/armed_q make
  // the receiver wait until nCS has been seen genuinely high after reset before
  // it accepts a falling edge, so a transaction cut by reset is ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync_q <= '0;
      copi_sync_q <= '0;
      ncs_sync_q  <= '1;
      sclk_hist_q <= 1'b0;
      ncs_hist_q  <= 1'b1;
      settle_q    <= '0;
      armed_q     <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], SCLK};
      copi_sync_q <= {copi_sync_q[SYNC_STAGES-2:0], COPI};
      ncs_sync_q  <= {ncs_sync_q[SYNC_STAGES-2:0], nCS};
      sclk_hist_q <= sclk_s;
      ncs_hist_q  <= ncs_s;
      settle_q    <= {settle_q[SYNC_STAGES-1:0], 1'b1};
      if (settle_q[SYNC_STAGES] && ncs_s) begin
        armed_q <= 1'b1;
      end
    end
  end

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign copi_s    = copi_sync_q[SYNC_STAGES-1];
  assign ncs_s     = ncs_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_hist_q;
  assign ncs_fall  = armed_q & ~ncs_s & ncs_hist_q;
  assign ncs_rise  = ncs_s & ~ncs_hist_q;

  state_t                  state_q;
  logic [FRAME_BITS-1:0]   shift_q;
  logic [CNT_W-1:0]        cnt_q;
  logic                    frame_valid_q, frame_err_q, frame_write_q, busy_q;
  logic [ADDR_BITS-1:0]    frame_addr_q;
  logic [DATA_BITS-1:0]    frame_data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      shift_q       <= '0;
      cnt_q         <= '0;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
      frame_write_q <= 1'b0;
      frame_addr_q  <= '0;
      frame_data_q  <= '0;
      busy_q        <= 1'b0;
    end else begin
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (ncs_fall) begin
            state_q <= RECV;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
            shift_q <= '0;
          end
        end
        RECV: begin
          // A bit arriving in the same cycle as nCS rising is still counted.
          if (sclk_rise) begin
            shift_q <= {shift_q[FRAME_BITS-2:0], copi_s};
            // Saturating at FRAME_BITS+1 marks an overrun without wrapping.
            if (cnt_q != CNT_SAT) begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          if (ncs_rise) begin
            state_q <= CHECK;
            busy_q  <= 1'b0;
          end
        end
        CHECK: begin
          if (cnt_q == CNT_FULL) begin
            frame_valid_q <= 1'b1;
            frame_write_q <= shift_q[FRAME_BITS-1];
            frame_addr_q  <= shift_q[FRAME_BITS-2 -: ADDR_BITS];
            frame_data_q  <= shift_q[DATA_BITS-1:0];
          end else begin
            frame_err_q <= 1'b1;
          end
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign frame_valid = frame_valid_q;
  assign frame_err   = frame_err_q;
  assign frame_write = frame_write_q;
  assign frame_addr  = frame_addr_q;
  assign frame_data  = frame_data_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_spi_frame_receiver.sv
// tb/tb_spi_frame_receiver.sv - scoreboard bench for spi_frame_receiver
module tb_spi_frame_receiver;

  localparam int SYNC_STAGES = 2;
  localparam int LATENCY     = SYNC_STAGES + 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       SCLK = 1'b0;
  logic       COPI = 1'b0;
  logic       nCS = 1'b1;
  logic       frame_valid, frame_write, frame_err, busy;
  logic [6:0] frame_addr;
  logic [7:0] frame_data;

  spi_frame_receiver #(.SYNC_STAGES(SYNC_STAGES), .ADDR_BITS(7), .DATA_BITS(8)) dut (
    .clk(clk), .rst(rst), .SCLK(SCLK), .COPI(COPI), .nCS(nCS),
    .frame_valid(frame_valid), .frame_write(frame_write), .frame_addr(frame_addr),
    .frame_data(frame_data), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit         is_err;
    logic       w;
    logic [6:0] a;
    logic [7:0] d;
  } exp_t;

  exp_t       exp_q[$];
  logic       m_w = 1'b0;
  logic [6:0] m_a = '0;
  logic [7:0] m_d = '0;
  int         vectors = 0;
  int         miscompares = 0;
  int         ncs_cyc = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected outcome of a frame of n bits: only 16-bit frames update the fields.
  task automatic push_frame(input logic [31:0] bits, input int n);
    exp_t e;
    if (n == 16) begin
      m_w = bits[15];
      m_a = bits[14:8];
      m_d = bits[7:0];
    end
    e.is_err = (n != 16);
    e.w = m_w;
    e.a = m_a;
    e.d = m_d;
    exp_q.push_back(e);
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Shift n bits MSB-first. coinc: last SCLK rise is driven together with nCS rise.
  task automatic send(input logic [31:0] bits, input int n, input int ph, input bit coinc);
    nCS = 1'b0;
    wait_neg(ph);
    for (int i = n - 1; i >= 0; i--) begin
      COPI = bits[i];
      wait_neg(ph);
      SCLK = 1'b1;
      if (coinc && i == 0) begin
        nCS = 1'b0 | 1'b1;
        ncs_cyc = cyc;
      end
      wait_neg(ph);
      SCLK = 1'b0;
    end
    if (!coinc) begin
      wait_neg(ph);
      nCS = 1'b1;
      ncs_cyc = cyc;
    end
  endtask

  // Watch the outputs for a bounded window; every pulse pops the scoreboard.
  task automatic drain(input string tag, input int window);
    exp_t e;
    bit   first = 1'b1;
    for (int i = 0; i < window; i++) begin
      @(negedge clk);
      if (frame_valid || frame_err) begin
        if (exp_q.size() == 0) begin
          chk({tag, "_unexpected_pulse"}, {frame_valid, frame_err}, 2'b00);
        end else begin
          e = exp_q.pop_front();
          chk({tag, "_valid"}, frame_valid, !e.is_err);
          chk({tag, "_err"}, frame_err, e.is_err);
          chk({tag, "_write"}, frame_write, e.w);
          chk({tag, "_addr"}, frame_addr, e.a);
          chk({tag, "_data"}, frame_data, e.d);
          if (first) chk({tag, "_latency"}, cyc - ncs_cyc, LATENCY);
        end
        first = 1'b0;
      end
    end
    chk({tag, "_missing_pulse"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    wait_neg(4);
    rst = 1'b0;
    wait_neg(1);
    chk("reset_valid", frame_valid, 1'b0);
    chk("reset_err", frame_err, 1'b0);
    chk("reset_fields", {frame_write, frame_addr, frame_data}, 16'h0000);
    chk("reset_busy", busy, 1'b0);
    wait_neg(8);

    // T1 write
    push_frame(32'h8155, 16);
    fork
      send(32'h8155, 16, 4, 1'b0);
      begin wait_neg(40); chk("t1_busy_mid", busy, 1'b1); end
    join
    drain("t1", 12);
    chk("t1_busy_after", busy, 1'b0);

    // T3 short frame: discard, fields still from T1
    push_frame(32'h7FFF, 15);
    send(32'h7FFF, 15, 4, 1'b0);
    drain("t3", 12);

    // T2 read, then outputs hold
    push_frame(32'h0300, 16);
    send(32'h0300, 16, 4, 1'b0);
    drain("t2", 12);
    wait_neg(20);
    chk("t2_hold", {frame_write, frame_addr, frame_data}, 16'h0300);

    // T4 overlong frame, then a good one
    push_frame(32'h109E1, 17);
    send(32'h109E1, 17, 4, 1'b0);
    drain("t4_long", 12);
    push_frame(32'h8201, 16);
    send(32'h8201, 16, 4, 1'b0);
    drain("t4_next", 12);

    // T5 reset mid-frame: remainder ignored
    send(32'hA5, 8, 4, 1'b1);
    nCS = 1'b0;
    rst = 1'b1;
    wait_neg(2);
    rst = 1'b0;
    m_w = 1'b0; m_a = '0; m_d = '0;
    for (int i = 7; i >= 0; i--) begin
      COPI = i[0];
      wait_neg(4); SCLK = 1'b1;
      wait_neg(4); SCLK = 1'b0;
    end
    chk("t5_busy_remainder", busy, 1'b0);
    wait_neg(4);
    nCS = 1'b1;
    ncs_cyc = cyc;
    drain("t5", 12);
    chk("t5_fields", {frame_write, frame_addr, frame_data}, 16'h0000);
    chk("t5_busy", busy, 1'b0);
    wait_neg(8);

    // T6 minimum SCLK phases, last rise coincident with nCS rise
    push_frame(32'h8AFF, 16);
    send(32'h8AFF, 16, SYNC_STAGES + 1, 1'b1);
    drain("t6", 12);
    chk("t6_fields", {frame_write, frame_addr, frame_data}, 16'h8AFF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
